// File: rtl/ifetch_ctrl_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input, decode handshake.
// Pure wiring, no latency of its own.
// Backpressure is carried by mem_stall_I (memory side) and inst_ready (decode side).
interface ifetch_ctrl_if;
  logic        mem_read_I;
  logic [29:0] mem_addr_I;
  logic [31:0] mem_rdata_I;
  logic        mem_stall_I;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] fetch_count;

  modport master (
    output mem_read_I, mem_addr_I, inst_valid, inst_out, inst_pc, fetch_count,
    input  mem_rdata_I, mem_stall_I, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_read_I, mem_addr_I, inst_valid, inst_out, inst_pc, fetch_count,
    output mem_rdata_I, mem_stall_I, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding memory read, one-entry output holding register.
// Latency: FETCH->HOLD per instruction, best case one instruction every 2 cycles.
// Backpressure: mem_stall_I holds the request address; inst_ready=0 parks the FSM in HOLD.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        mem_read;
  logic        done;
  logic [31:0] tgt;
  logic        unused_redirect_lsbs;

  // Memory request is a pure decode of the state; address is the word part of pc.
  assign mem_read             = (state_q == FETCH) || (state_q == DROP);
  assign done                 = mem_read && !bus.mem_stall_I;
  assign tgt                  = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  assign bus.mem_read_I  = mem_read;
  assign bus.mem_addr_I  = pc_q[31:2];
  assign bus.inst_valid  = inst_valid_q;
  assign bus.inst_out    = inst_out_q;
  assign bus.inst_pc     = inst_pc_q;
  assign bus.fetch_count = fetch_count_q;

  // Next-state logic: redirects always win over the normal sequential flow.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    inst_valid_d  = inst_valid_q;
    inst_out_d    = inst_out_q;
    inst_pc_d     = inst_pc_q;
    fetch_count_d = fetch_count_q;

    // A handshake counts even when a redirect flushes the same cycle.
    if (inst_valid_q && bus.inst_ready) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (bus.redirect_valid) pc_d = tgt;
      end
      FETCH: begin
        if (bus.redirect_valid) begin
          if (done) begin
            pc_d = tgt;             // data for the old path is dropped
          end else begin
            pend_pc_d = tgt;        // address must stay put until the access ends
            state_d   = DROP;
          end
        end else if (done) begin
          inst_out_d   = bus.mem_rdata_I;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + 32'd4;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          inst_valid_d = 1'b0;
          pc_d         = tgt;
          state_d      = FETCH;
        end else if (bus.inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      DROP: begin
        if (bus.redirect_valid) pend_pc_d = tgt;
        if (done) begin
          pc_d    = bus.redirect_valid ? tgt : pend_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; an in-flight access is simply abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_pc_q     <= 32'd0;
      inst_valid_q  <= 1'b0;
      inst_out_q    <= 32'd0;
      inst_pc_q     <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      inst_valid_q  <= inst_valid_d;
      inst_out_q    <= inst_out_d;
      inst_pc_q     <= inst_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl; memory returns {2'b10, word address} with zero latency.
// Inputs change and outputs are checked on the falling edge.
// Stall and ready are driven explicitly by each scenario task.
module tb_ifetch_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  ifetch_ctrl_if bus();

  ifetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mem_rdata_I = {2'b10, bus.mem_addr_I};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.mem_stall_I = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0; bus.inst_ready = 1'b0;
    step(); step();
    total++; if (bus.mem_read_I !== 1'b0) begin bad++; $display("FAIL rst_read got=%b want=0", bus.mem_read_I); end
    total++; if (bus.mem_addr_I !== 30'd0) begin bad++; $display("FAIL rst_addr got=%h want=0", bus.mem_addr_I); end
    total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.inst_valid); end
    total++; if (bus.inst_out !== 32'd0 || bus.inst_pc !== 32'd0) begin bad++; $display("FAIL rst_inst got=%h/%h want=0/0", bus.inst_out, bus.inst_pc); end
    total++; if (bus.fetch_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.fetch_count); end
  endtask

  task automatic test_stream();
    rst = 1'b0; bus.inst_ready = 1'b1;
    step();  // IDLE -> FETCH
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.mem_read_I !== 1'b1 || bus.mem_addr_I !== 30'(i)) begin bad++; $display("FAIL stream_req%0d got=%b/%h want=1/%h", i, bus.mem_read_I, bus.mem_addr_I, i); end
      step();
      total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4*i)) begin bad++; $display("FAIL stream_inst%0d got=%b/%h want=1/%h", i, bus.inst_valid, bus.inst_pc, 4*i); end
      total++; if (bus.inst_out !== (32'h8000_0000 | 32'(i)) || bus.mem_read_I !== 1'b0) begin bad++; $display("FAIL stream_data%0d got=%h/%b want=%h/0", i, bus.inst_out, bus.mem_read_I, 32'h8000_0000 | 32'(i)); end
      step();
    end
    total++; if (bus.fetch_count !== 32'd3) begin bad++; $display("FAIL stream_count got=%0d want=3", bus.fetch_count); end
  endtask

  task automatic test_stall();
    step(); step();  // finish word 3, now FETCH at word 4 (0x10)
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.mem_read_I !== 1'b1 || bus.mem_addr_I !== 30'h4 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got=%b/%h/%b want=1/4/0", k, bus.mem_read_I, bus.mem_addr_I, bus.inst_valid); end
      bus.mem_stall_I = (k < 3);
      step();
    end
    total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h10 || bus.inst_out !== 32'h8000_0004) begin bad++; $display("FAIL stall_done got=%b/%h/%h want=1/10/80000004", bus.inst_valid, bus.inst_pc, bus.inst_out); end
  endtask

  task automatic test_redirect_drop();
    for (int k = 0; k < 7; k++) step();  // fetch 0x14..0x1C, now FETCH 0x20
    total++; if (bus.mem_addr_I !== 30'h8 || bus.mem_read_I !== 1'b1) begin bad++; $display("FAIL drop_pre got=%h/%b want=8/1", bus.mem_addr_I, bus.mem_read_I); end
    bus.mem_stall_I = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    step();
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (bus.mem_addr_I !== 30'h8 || bus.mem_read_I !== 1'b1 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL drop_wait%0d got=%h/%b/%b want=8/1/0", k, bus.mem_addr_I, bus.mem_read_I, bus.inst_valid); end
      bus.mem_stall_I = (k == 0);
      step();
    end
    total++; if (bus.mem_addr_I !== 30'h80 || bus.mem_read_I !== 1'b1 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL drop_next got=%h/%b/%b want=80/1/0", bus.mem_addr_I, bus.mem_read_I, bus.inst_valid); end
    total++; if (bus.fetch_count !== 32'd8) begin bad++; $display("FAIL drop_count got=%0d want=8", bus.fetch_count); end
  endtask

  task automatic test_backpressure();
    bus.inst_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h200 || bus.inst_out !== 32'h8000_0080) begin bad++; $display("FAIL bp_inst%0d got=%b/%h/%h want=1/200/80000080", k, bus.inst_valid, bus.inst_pc, bus.inst_out); end
      total++; if (bus.mem_read_I !== 1'b0 || bus.fetch_count !== 32'd8) begin bad++; $display("FAIL bp_idle%0d got=%b/%0d want=0/8", k, bus.mem_read_I, bus.fetch_count); end
      step();
    end
    bus.inst_ready = 1'b1;
    step();
    total++; if (bus.fetch_count !== 32'd9 || bus.inst_valid !== 1'b0 || bus.mem_addr_I !== 30'h81) begin bad++; $display("FAIL bp_release got=%0d/%b/%h want=9/0/81", bus.fetch_count, bus.inst_valid, bus.mem_addr_I); end
  endtask

  task automatic test_redirect_hold();
    bus.inst_ready = 1'b0;
    step();
    total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h204) begin bad++; $display("FAIL rh_pre got=%b/%h want=1/204", bus.inst_valid, bus.inst_pc); end
    bus.inst_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h103;
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.fetch_count !== 32'd10 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL rh_count got=%0d/%b want=10/0", bus.fetch_count, bus.inst_valid); end
    total++; if (bus.mem_read_I !== 1'b1 || bus.mem_addr_I !== 30'h40) begin bad++; $display("FAIL rh_addr got=%b/%h want=1/40", bus.mem_read_I, bus.mem_addr_I); end
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    step();  // redirect coincides with completion: stay in FETCH
    bus.redirect_valid = 1'b0;
    total++; if (bus.mem_addr_I !== 30'h3FFF_FFFF || bus.mem_read_I !== 1'b1 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL wrap_req got=%h/%b/%b want=3fffffff/1/0", bus.mem_addr_I, bus.mem_read_I, bus.inst_valid); end
    step();
    total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hFFFF_FFFC || bus.inst_out !== 32'hBFFF_FFFF) begin bad++; $display("FAIL wrap_inst got=%b/%h/%h want=1/fffffffc/bfffffff", bus.inst_valid, bus.inst_pc, bus.inst_out); end
    step();
    total++; if (bus.mem_addr_I !== 30'd0 || bus.mem_read_I !== 1'b1 || bus.fetch_count !== 32'd11) begin bad++; $display("FAIL wrap_next got=%h/%b/%0d want=0/1/11", bus.mem_addr_I, bus.mem_read_I, bus.fetch_count); end
  endtask

  task automatic test_drop_latest();
    bus.mem_stall_I = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h400;
    step();
    bus.redirect_pc = 32'h500;
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.mem_addr_I !== 30'd0 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL latest_wait got=%h/%b want=0/0", bus.mem_addr_I, bus.inst_valid); end
    bus.mem_stall_I = 1'b0;
    step();
    total++; if (bus.mem_addr_I !== 30'h140 || bus.mem_read_I !== 1'b1 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL latest_next got=%h/%b/%b want=140/1/0", bus.mem_addr_I, bus.mem_read_I, bus.inst_valid); end
  endtask

  task automatic test_reset_mid_stall();
    bus.mem_stall_I = 1'b1;
    step();
    rst = 1'b1;
    step();
    total++; if (bus.mem_read_I !== 1'b0 || bus.inst_valid !== 1'b0) begin bad++; $display("FAIL rms_out got=%b/%b want=0/0", bus.mem_read_I, bus.inst_valid); end
    total++; if (bus.mem_addr_I !== 30'd0 || bus.fetch_count !== 32'd0) begin bad++; $display("FAIL rms_state got=%h/%0d want=0/0", bus.mem_addr_I, bus.fetch_count); end
    rst = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h84;  // redirect while IDLE
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.mem_read_I !== 1'b1 || bus.mem_addr_I !== 30'h21) begin bad++; $display("FAIL idle_redir got=%b/%h want=1/21", bus.mem_read_I, bus.mem_addr_I); end
    bus.mem_stall_I = 1'b0;
    step();
    total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h84) begin bad++; $display("FAIL idle_inst got=%b/%h want=1/84", bus.inst_valid, bus.inst_pc); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_backpressure();
    test_redirect_hold();
    test_wrap();
    test_drop_latest();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 The block SHALL have parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset (bits [1:0] SHALL be zero).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port: mem_read_I  output  1  instruction-memory read request.
REQ-005 The block SHALL have port: mem_addr_I  output  30 ([31:2])  word address of the current fetch.
REQ-006 The block SHALL have port: mem_rdata_I  input  32  instruction word, valid in the cycle of completion.
REQ-007 The block SHALL have port: mem_stall_I  input  1  high while the memory access is still in progress.
REQ-008 The block SHALL have port: redirect_valid  input  1  one-cycle pulse requesting a fetch from redirect_pc.
REQ-009 The block SHALL have port: redirect_pc  input  32  target byte address; bits [1:0] ignored and treated as 0.
REQ-010 The block SHALL have port: inst_valid  output  1  inst_out/inst_pc hold a fetched instruction.
REQ-011 The block SHALL have port: inst_ready  input  1  decode stage accepts the instruction.
REQ-012 The block SHALL have port: inst_out  output  32  fetched instruction word.
REQ-013 The block SHALL have port: inst_pc  output  32  byte address of inst_out.
REQ-014 The block SHALL have port: fetch_count  output  32  number of instructions accepted (inst_valid & inst_ready).

Function
REQ-015 The block SHALL implement FSM states IDLE, FETCH, HOLD, DROP, with IDLE as the reset state.
REQ-016 IDLE SHALL drive mem_read_I=0 and SHALL move to FETCH on the next cycle.
REQ-017 FETCH and DROP SHALL drive mem_read_I=1 and mem_addr_I=pc[31:2], held stable until completion.
REQ-018 A memory access SHALL complete in any cycle with mem_read_I=1 and mem_stall_I=0.
REQ-019 In FETCH on completion without redirect, the block SHALL register inst_out<=mem_rdata_I, inst_pc<=pc, inst_valid<=1, and pc<=pc+4, then go to HOLD.
REQ-020 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 yields 32'h0000_0000.
REQ-021 HOLD SHALL keep mem_read_I=0 and inst_out/inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-022 In HOLD with inst_ready=1, the block SHALL clear inst_valid, increment fetch_count, and go to FETCH.
REQ-023 With zero-stall memory, minimum throughput SHALL be one instruction per 2 cycles (FETCH, HOLD).
REQ-024 A redirect in FETCH while mem_stall_I=1 SHALL latch the target into pend_pc and go to DROP, without changing mem_addr_I mid-access.
REQ-025 In DROP on completion, the block SHALL discard mem_rdata_I, set pc<=pend_pc, and go to FETCH; inst_valid SHALL stay 0.
REQ-026 A redirect in DROP SHALL overwrite pend_pc (latest redirect wins).
REQ-027 A redirect in FETCH coinciding with completion SHALL discard the data, set pc<=redirect target, and stay in FETCH.
REQ-028 A redirect in HOLD SHALL clear inst_valid, set pc<=redirect target, and go to FETCH.
REQ-029 If inst_ready=1 in the same HOLD cycle as a redirect, the handshake SHALL count as accepted (fetch_count increments) and the redirect SHALL still apply.
REQ-030 A redirect in IDLE SHALL set pc<=redirect target and proceed to FETCH.
REQ-031 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, pend_pc=0, inst_valid=0, inst_out=0, inst_pc=0, fetch_count=0; mem_read_I=0 and mem_addr_I=RESET_PC[31:2] SHALL follow from the reset state.
REQ-033 Reset SHALL take priority over all other inputs, including mid-stall accesses; the abandoned access is not tracked.

Verification
REQ-034 The bench SHALL cover: reset, stall=0 always, inst_ready=1 -> fetches at word addresses 0,1,2,...; inst_pc 0,4,8; fetch_count=3 after 6 cycles of FETCH/HOLD.
REQ-035 The bench SHALL cover: mem_stall_I=1 for 3 cycles on fetch at 0x10 -> mem_addr_I stays 0x4 for 4 cycles, then inst_valid=1 with inst_pc=0x10.
REQ-036 The bench SHALL cover: redirect to 0x200 during stall at 0x20 -> DROP, data discarded, next request at mem_addr_I=0x80, inst_valid never set for 0x20.
REQ-037 The bench SHALL cover: inst_ready=0 for 5 cycles in HOLD -> inst_out/inst_pc constant, mem_read_I=0, fetch_count unchanged.
REQ-038 The bench SHALL cover: redirect to 0x103 with inst_ready=1 in HOLD -> fetch_count+1, next fetch at byte address 0x100.
REQ-039 The bench SHALL cover: pc=0xFFFF_FFFC completion -> next fetch at 0; rst asserted mid-stall -> next cycle mem_read_I=0, inst_valid=0, pc=RESET_PC.
